prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Parametrised PRBS receiver-side checker, companion to the LFSR pattern source.
//  Self-synchronises a Fibonacci LFSR to the recovered bitstream from the CDR and counts bit errors once locked.
//  Runs a lock FSM with loss-of-sync detection for link bring-up and BER measurement.
//  Sits after the CDR sampler; one bit per din_valid strobe.
// PARAMETERS
//  POLY_LEN     9    LFSR order N; polynomial x^N + x^TAP + 1; range 3..31
//  POLY_TAP     5    middle tap T, 1 <= T < N
//  LOCK_CNT     16   consecutive correct predictions needed to declare lock
//  WIN_LEN      256  loss-of-sync observation window, in valid bits
//  LOSS_THRESH  8    errors within one window that force loss of lock
//  ERR_W        16   width of error counter
// PORTS
//  clk        in   1      bit clock, rising edge
//  rst        in   1      reset, asynchronous, active-low
//  din        in   1      recovered data bit
//  din_valid  in   1      din qualifier; all state frozen when low
//  err_clr    in   1      synchronous clear of err_cnt
//  locked     out  1      checker in LOCKED state
//  err_pulse  out  1      one-cycle strobe per detected bit error
//  sync_lost  out  1      one-cycle strobe on LOCKED->SEARCH transition
//  err_cnt    out  ERR_W  saturating count of errors while locked
// BEHAVIOUR
//  - Reset (rst low): state=SEARCH, lfsr=0, fill/match/window/window-error counters=0; all outputs 0.
//  - lfsr[N-1:0] shifts left, new bit into bit0. Prediction p = lfsr[N-1] ^ lfsr[T-1].
//  - Only cycles with din_valid=1 advance anything. Outputs are registered: err_pulse/sync_lost/locked
//    change the cycle after the din_valid sample that caused them.
//  - SEARCH: shift raw din into lfsr; fill count increments. After N bits: if lfsr != 0 -> VERIFY,
//    else restart fill (all-zero state never accepted).
//  - VERIFY: compare din with p; shift p into lfsr. Match: match count++; reaching LOCK_CNT -> LOCKED,
//    locked=1. Mismatch: -> SEARCH, fill and match counters cleared. err_cnt not touched.
//  - LOCKED: shift p (free-running, never din). Mismatch: err_pulse=1, err_cnt++ saturating at all-ones,
//    window error count++. Window counter counts valid bits 0..WIN_LEN-1 then wraps, clearing window errors.
//    Window errors reaching LOSS_THRESH -> SEARCH, locked=0, sync_lost=1, all counters except err_cnt cleared.
//  - Same-cycle mismatch completing LOSS_THRESH and window wrap: loss of lock wins.
//  - err_clr=1: err_cnt=0 next cycle; if a mismatch is detected in the same cycle, err_cnt=1.
//  - err_cnt holds its value across loss/reacquire; cleared only by reset or err_clr.
//  - rst asserted mid-operation: immediate return to reset values, no sync_lost strobe.
// CONFIGURATION
//  PRBS_CHK_BITCNT_EN defined: adds output bit_cnt [31:0], counts valid bits while LOCKED, saturating at
//   all-ones, cleared by err_clr and reset; gives BER = err_cnt/bit_cnt.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package prbs_pkg: state enum {SEARCH, VERIFY, LOCKED}; standard (N,T) constants
//   PRBS7=(7,6), PRBS9=(9,5), PRBS15=(15,14), PRBS23=(23,18), PRBS31=(31,28).
//  Sub-module prbs_lfsr_core (N, T parameters): lfsr register, prediction output, load-raw vs
//   shift-predicted select; shared with future parametrised generator. FSM and counters in top.
// TESTING (defaults; reference model = PRBS9 generator, seed 9'h1FF)
//  1 Clean stream, din_valid=1: locked rises after 9+16 valid bits (+1 reg cycle); 1000 further bits,
//    err_cnt=0, no err_pulse.
//  2 Locked, flip one bit: exactly one err_pulse one cycle later, err_cnt=1, locked stays 1.
//  3 Locked, flip 8 bits within 256-bit window: sync_lost pulse, locked=0, reacquire after 25 clean bits,
//    err_cnt=8 retained.
//  4 Constant din=0 for 100 bits: never leaves SEARCH, locked=0.
//  5 din_valid toggled 1/0 every cycle on clean stream: lock after 25 valid bits, no errors;
//    err_clr with simultaneous error -> err_cnt=1.
//  6 Drive err_cnt to 16'hFFFF via forced errors (LOSS_THRESH raised): stays 16'hFFFF; rst mid-VERIFY returns all outputs to 0.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: lock-FSM state encoding, standard (N, T) polynomial pairs
// and a counter-width helper used by the checker and the future generator.
package prbs_pkg;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } prbs_state_e;

  // Polynomial x^N + x^T + 1 for the common ITU-T patterns.
  localparam int unsigned PRBS7_N  = 7;
  localparam int unsigned PRBS7_T  = 6;
  localparam int unsigned PRBS9_N  = 9;
  localparam int unsigned PRBS9_T  = 5;
  localparam int unsigned PRBS15_N = 15;
  localparam int unsigned PRBS15_T = 14;
  localparam int unsigned PRBS23_N = 23;
  localparam int unsigned PRBS23_T = 18;
  localparam int unsigned PRBS31_N = 31;
  localparam int unsigned PRBS31_T = 28;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// Fibonacci LFSR for x^N + x^T + 1: shifts left, new bit into bit 0, either the raw
// input bit (seeding) or its own prediction (free-running).
module prbs_lfsr_core #(
  parameter int unsigned N = 9,
  parameter int unsigned T = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic         load_raw,
  input  logic         din,
  output logic         pred,
  output logic [N-1:0] lfsr_next
);

  logic [N-1:0] lfsr_q;

  assign pred      = lfsr_q[N-1] ^ lfsr_q[T-1];
  assign lfsr_next = {lfsr_q[N-2:0], (load_raw ? din : pred)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= '0;
    end else if (shift) begin
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker with lock FSM, loss-of-sync window and error counter.
// Define PRBS_CHK_BITCNT_EN to add the bit_cnt output for BER measurement.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned POLY_LEN    = PRBS9_N,
  parameter int unsigned POLY_TAP    = PRBS9_T,
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned WIN_LEN     = 256,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_lost,
`ifdef PRBS_CHK_BITCNT_EN
  output logic [31:0]      bit_cnt,
`endif
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned FillW   = cnt_width(POLY_LEN - 1);
  localparam int unsigned MatchW  = cnt_width(LOCK_CNT - 1);
  localparam int unsigned WinW    = cnt_width(WIN_LEN - 1);
  localparam int unsigned WinErrW = cnt_width(LOSS_THRESH - 1);

  prbs_state_e          state_q;
  logic [FillW-1:0]     fill_q;
  logic [MatchW-1:0]    match_q;
  logic [WinW-1:0]      win_q;
  logic [WinErrW-1:0]   win_err_q;

  logic                 pred;
  logic                 load_raw;
  logic [POLY_LEN-1:0]  lfsr_next;
  logic                 mismatch;
  logic                 fill_done;
  logic                 match_done;
  logic                 win_wrap;
  logic                 loss;
  logic                 err_hit;

  assign load_raw = (state_q == StSearch);

  prbs_lfsr_core #(
    .N (POLY_LEN),
    .T (POLY_TAP)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .shift     (din_valid),
    .load_raw  (load_raw),
    .din       (din),
    .pred      (pred),
    .lfsr_next (lfsr_next)
  );

  always_comb begin
    mismatch   = din ^ pred;
    fill_done  = (fill_q == FillW'(POLY_LEN - 1));
    match_done = (match_q == MatchW'(LOCK_CNT - 1));
    win_wrap   = (win_q == WinW'(WIN_LEN - 1));
    // Loss is judged on the count including this bit, so it beats a same-cycle wrap.
    loss       = mismatch && (win_err_q == WinErrW'(LOSS_THRESH - 1));
    err_hit    = din_valid && (state_q == StLocked) && mismatch;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StSearch;
      fill_q    <= '0;
      match_q   <= '0;
      win_q     <= '0;
      win_err_q <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= err_hit;
      sync_lost <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          StSearch: begin
            if (fill_done) begin
              fill_q <= '0;
              // All-zero seed would lock onto a dead stream; refill instead.
              if (|lfsr_next) begin
                state_q <= StVerify;
              end
            end else begin
              fill_q <= fill_q + FillW'(1);
            end
          end
          StVerify: begin
            if (mismatch) begin
              state_q <= StSearch;
              fill_q  <= '0;
              match_q <= '0;
            end else if (match_done) begin
              state_q <= StLocked;
              locked  <= 1'b1;
              match_q <= '0;
            end else begin
              match_q <= match_q + MatchW'(1);
            end
          end
          StLocked: begin
            if (loss) begin
              state_q   <= StSearch;
              locked    <= 1'b0;
              sync_lost <= 1'b1;
              fill_q    <= '0;
              match_q   <= '0;
              win_q     <= '0;
              win_err_q <= '0;
            end else if (win_wrap) begin
              win_q     <= '0;
              win_err_q <= '0;
            end else begin
              win_q     <= win_q + WinW'(1);
              win_err_q <= win_err_q + WinErrW'(mismatch);
            end
          end
          default: begin
            state_q <= StSearch;
            locked  <= 1'b0;
          end
        endcase
      end
      if (err_clr) begin
        err_cnt <= ERR_W'(err_hit);
      end else if (err_hit && !(&err_cnt)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (err_clr) begin
      bit_cnt <= '0;
    end else if (din_valid && (state_q == StLocked) && !(&bit_cnt)) begin
      bit_cnt <= bit_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: stimulus queues expected strobes/probes, a monitor
// pops and compares them whenever the DUT presents an output.
module tb_prbs_checker;

  typedef enum logic [2:0] {KErr, KSync, KLock, KProbe, KProbeSat} kind_e;
  typedef struct packed {
    kind_e       kind;
    logic        lk;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        din, din_valid, err_clr;
  logic        locked, err_pulse, sync_lost;
  logic [15:0] err_cnt;
  logic        sat_din, sat_valid, sat_clr;
  logic        sat_locked, sat_pulse, sat_lost;
  logic [3:0]  sat_err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_cnt, sat_bit_cnt;
`endif

  logic        probe, probe_sat;
  logic        stim_done = 1'b0;
  logic [8:0]  g, sg;
  int          nbits;
  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          sat_pulses = 0;
  int          sat_losts = 0;
  logic        prev_locked = 1'b0;

  always #5 clk = ~clk;

  prbs_checker u_dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .sync_lost (sync_lost),
`ifdef PRBS_CHK_BITCNT_EN
    .bit_cnt   (bit_cnt),
`endif
    .err_cnt   (err_cnt)
  );

  // Narrow counter and unreachable loss threshold so saturation is cheap to reach.
  prbs_checker #(
    .ERR_W       (4),
    .LOSS_THRESH (300)
  ) u_sat (
    .clk       (clk),
    .rst       (rst),
    .din       (sat_din),
    .din_valid (sat_valid),
    .err_clr   (sat_clr),
    .locked    (sat_locked),
    .err_pulse (sat_pulse),
    .sync_lost (sat_lost),
`ifdef PRBS_CHK_BITCNT_EN
    .bit_cnt   (sat_bit_cnt),
`endif
    .err_cnt   (sat_err_cnt)
  );

  // ---------------- stimulus helpers ----------------
  task automatic expect_ev(input kind_e k, input logic lk, input int cnt);
    exp_t e;
    e.kind = k;
    e.lk   = lk;
    e.cnt  = 16'(cnt);
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    err_clr   = 1'b0;
    sat_valid = 1'b0;
    sat_clr   = 1'b0;
    probe     = 1'b0;
    probe_sat = 1'b0;
  endtask

  // Next PRBS9 reference bit (x^9 + x^5 + 1), optionally inverted.
  task automatic send(input logic flip, input logic clr = 1'b0);
    logic b;
    b = g[8] ^ g[4];
    g = {g[7:0], b};
    din       = b ^ flip;
    din_valid = 1'b1;
    err_clr   = clr;
    tick();
    nbits++;
  endtask

  task automatic send_idle();
    din = 1'($urandom_range(1, 0));
    tick();
  endtask

  task automatic send_raw(input logic d);
    din       = d;
    din_valid = 1'b1;
    tick();
  endtask

  task automatic sat_send(input logic flip, input logic clr = 1'b0);
    logic b;
    b = sg[8] ^ sg[4];
    sg = {sg[7:0], b};
    sat_din   = b ^ flip;
    sat_valid = 1'b1;
    sat_clr   = clr;
    tick();
  endtask

  task automatic clean(input int n);
    repeat (n) send(1'b0);
  endtask

  task automatic pad_to(input int r);
    while (nbits % 256 != r) send(1'b0);
  endtask

  task automatic probe_chk(input logic lk, input int cnt);
    expect_ev(KProbe, lk, cnt);
    probe = 1'b1;
    tick();
  endtask

  task automatic probe_sat_chk(input logic lk, input int cnt);
    expect_ev(KProbeSat, lk, cnt);
    probe_sat = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input kind_e k, input logic lk, input logic [15:0] cnt);
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL %s @%0t: unexpected output locked=%0b err_cnt=%0d, nothing expected",
               k.name(), $time, lk, cnt);
      return;
    end
    e = q.pop_front();
    if (e.kind != k || e.lk != lk || e.cnt != cnt) begin
      miscompares++;
      $display("FAIL %s @%0t: got locked=%0b err_cnt=%0d, want %s locked=%0b err_cnt=%0d",
               k.name(), $time, lk, cnt, e.kind.name(), e.lk, e.cnt);
    end
  endtask

  initial begin : monitor
    while (!stim_done) begin
      @(negedge clk);
      if (rst) begin
        if (err_pulse) check(KErr, locked, err_cnt);
        if (sync_lost) check(KSync, locked, err_cnt);
        if (locked && !prev_locked) check(KLock, locked, err_cnt);
        if (!locked && prev_locked && !sync_lost) begin
          vectors++;
          miscompares++;
          $display("FAIL lock_drop @%0t: locked fell without sync_lost", $time);
        end
        if (probe) check(KProbe, locked, err_cnt);
        if (probe_sat) check(KProbeSat, sat_locked, 16'(sat_err_cnt));
        if (sat_pulse) sat_pulses++;
        if (sat_lost) sat_losts++;
      end
      prev_locked = locked;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending: %0d expected outputs never seen, want 0", q.size());
    end
    vectors++;
    if (sat_pulses != 20) begin
      miscompares++;
      $display("FAIL sat_pulses: got %0d err_pulse strobes, want 20", sat_pulses);
    end
    vectors++;
    if (sat_losts != 0) begin
      miscompares++;
      $display("FAIL sat_lost: got %0d sync_lost strobes, want 0", sat_losts);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    rst = 1'b0;
    din = 1'b0; din_valid = 1'b0; err_clr = 1'b0;
    sat_din = 1'b0; sat_valid = 1'b0; sat_clr = 1'b0;
    probe = 1'b0; probe_sat = 1'b0;
    g = 9'h1FF; sg = 9'h1FF; nbits = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // 1: reset state, lock after 9 + 16 valid bits, 1000 clean bits
    probe_chk(1'b0, 0);
    clean(24);
    probe_chk(1'b0, 0);
    expect_ev(KLock, 1'b1, 0);
    send(1'b0);
    nbits = 0;
    probe_chk(1'b1, 0);
    clean(1000);
    probe_chk(1'b1, 0);

    // 2: single flipped bit
    expect_ev(KErr, 1'b1, 1);
    send(1'b1);
    probe_chk(1'b1, 1);
    send(1'b0, 1'b1);
    probe_chk(1'b1, 0);

    // 3: 7 errors then window wrap clears them; 8 errors with last on the wrap bit -> loss
    pad_to(0);
    for (int k = 0; k < 7; k++) begin
      expect_ev(KErr, 1'b1, k + 1);
      send(1'b1);
      send(1'b0);
    end
    pad_to(0);
    probe_chk(1'b1, 7);
    send(1'b0, 1'b1);
    probe_chk(1'b1, 0);
    for (int k = 0; k < 7; k++) begin
      expect_ev(KErr, 1'b1, k + 1);
      send(1'b1);
      send(1'b0);
    end
    pad_to(255);
    expect_ev(KErr, 1'b0, 8);
    expect_ev(KSync, 1'b0, 8);
    send(1'b1);
    probe_chk(1'b0, 8);
    clean(24);
    probe_chk(1'b0, 8);
    expect_ev(KLock, 1'b1, 8);
    send(1'b0);
    nbits = 0;
    probe_chk(1'b1, 8);

    // 4: constant zero never locks
    do_reset();
    probe_chk(1'b0, 0);
    repeat (100) send_raw(1'b0);
    probe_chk(1'b0, 0);

    // 5: din_valid toggling, lock on 25th valid bit; err_clr with simultaneous error
    do_reset();
    for (int i = 0; i < 25; i++) begin
      if (i == 24) begin
        probe_chk(1'b0, 0);
        expect_ev(KLock, 1'b1, 0);
      end
      send(1'b0);
      send_idle();
    end
    nbits = 0;
    probe_chk(1'b1, 0);
    repeat (10) begin
      send(1'b0);
      send_idle();
    end
    expect_ev(KErr, 1'b1, 1);
    send(1'b1);
    clean(3);
    expect_ev(KErr, 1'b1, 1);
    send(1'b1, 1'b1);
    probe_chk(1'b1, 1);

    // 6a: consecutive errors -> loss, refill into VERIFY, reset mid-VERIFY, relock
    pad_to(0);
    for (int k = 0; k < 7; k++) begin
      expect_ev(KErr, 1'b1, k + 2);
      send(1'b1);
    end
    expect_ev(KErr, 1'b0, 9);
    expect_ev(KSync, 1'b0, 9);
    send(1'b1);
    probe_chk(1'b0, 9);
    clean(12);
    probe_chk(1'b0, 9);
    do_reset();
    probe_chk(1'b0, 0);
    clean(24);
    probe_chk(1'b0, 0);
    expect_ev(KLock, 1'b1, 0);
    send(1'b0);
    probe_chk(1'b1, 0);

    // 6b: saturation on the 4-bit instance
    repeat (24) sat_send(1'b0);
    probe_sat_chk(1'b0, 0);
    sat_send(1'b0);
    probe_sat_chk(1'b1, 0);
    repeat (14) sat_send(1'b1);
    probe_sat_chk(1'b1, 14);
    sat_send(1'b1);
    probe_sat_chk(1'b1, 15);
    repeat (5) sat_send(1'b1);
    probe_sat_chk(1'b1, 15);
    sat_send(1'b0, 1'b1);
    probe_sat_chk(1'b1, 0);

    repeat (3) tick();
    stim_done = 1'b1;
  end

endmodule
